disc_sample_feeder: RTL and testbench
=====================================

# disc_sample_feeder

Upstream feeder for the discriminator pipeline. It latches one 256-sample Q8.8 frame (for example, a generator output image) as a flat vector and streams it sample-by-sample into the discriminator's 256-deep sample FIFO, honouring FIFO backpressure. Once the whole frame is queued, it starts the discriminator, holds the start request until the pipeline accepts it, and waits for completion. The top level can therefore hand it frames without tracking FIFO levels or pipeline state.

## Interface
- SAMPLE_COUNT, 256, samples per frame; must equal the sample FIFO depth.
- DATA_WIDTH, 16, sample width, signed Q8.8.
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset, synchronous, active-high.
- load  in  1  frame-load request; accepted only when frame_ready=1.
- frame_flat  in  DATA_WIDTH*SAMPLE_COUNT  frame; sample i is at bits [16i+15:16i].
- frame_ready  out  1  high in IDLE only.
- fifo_wr_en  out  1  sample FIFO write strobe (combinational).
- fifo_wr_data  out  DATA_WIDTH  sample FIFO write data (combinational).
- fifo_full  in  1  sample FIFO full flag.
- disc_start  out  1  discriminator start request (registered, level-held).
- disc_busy  in  1  discriminator busy.
- disc_done  in  1  discriminator one-cycle done pulse.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse when the discriminator finishes this frame.
- frames_sent  out  16  count of completed frames; wraps 0xFFFF→0.

## Operation
- FSM states: IDLE, WRITE, START, WAIT_DONE.
- IDLE:
  - frame_ready=1.
  - On load=1, latch frame_flat into the shadow register, clear idx, go to WRITE.
  - load in any other state is ignored; the shadow register is not updated.
- WRITE:
  - fifo_wr_en = !fifo_full.
  - fifo_wr_data = shadow sample[idx], processed per Configuration.
  - Each cycle with fifo_wr_en=1: idx++. When idx reaches SAMPLE_COUNT-1 on such a cycle, go to START.
  - While fifo_full=1: no write, idx holds, no sample is lost or duplicated.
- START:
  - disc_start=1, held until disc_busy=1 is sampled.
  - Then deassert disc_start and go to WAIT_DONE.
- WAIT_DONE:
  - On disc_done=1: pulse frame_done, increment frames_sent, return to IDLE.
- Sample order into the FIFO is index 0 first, matching the pipeline's buffer layout.
- The feeder never reads the FIFO and never flushes it. FIFO contents on reset are the FIFO owner's responsibility; the FIFO shares rst.

## Timing
- Reset values:
  - State: IDLE.
  - frame_ready=1; busy=0, disc_start=0, frame_done=0, fifo_wr_en=0, frames_sent=0, idx=0.
  - The shadow register is cleared to 0.
- Load accepted at edge N:
  - busy=1 and frame_ready=0 from cycle N+1.
  - With no backpressure, writes occur in cycles N+1..N+SAMPLE_COUNT.
  - disc_start=1 from cycle N+SAMPLE_COUNT+1.
- Each cycle with fifo_full=1 delays all later events by exactly one cycle.
- disc_start deasserts the cycle after disc_busy=1 is sampled.
- frame_done is high the cycle after disc_done; frames_sent updates on the same edge.
- The earliest next load is accepted the cycle after frame_done.
- Simultaneous disc_done and load in WAIT_DONE: load is ignored (frame_ready=0).
- rst asserted in any state returns to the reset values at the next edge. A partially written frame is abandoned, and disc_start drops immediately.

## Configuration
- DISC_FEEDER_CLAMP_EN defined:
  - Each sample is saturated to [-256, +256] (±1.0 Q8.8) before fifo_wr_data.
  - The comparison is signed 16-bit.
- Undefined: samples pass through unmodified.
- Latency is identical in both builds.

## Test plan
- Reset, then load a ramp frame (sample i = i), fifo_full=0, disc_busy asserted 2 cycles after disc_start, disc_done 10 cycles later:
  - Exactly 256 writes, data 0..255 in order, in cycles N+1..N+256.
  - disc_start high at N+257.
  - frame_done pulse one cycle after disc_done; frames_sent=1.
- Toggle fifo_full every other cycle during WRITE:
  - All 256 samples written, none duplicated or lost.
  - disc_start delayed by exactly the number of full cycles.
- Pulse load during WRITE with a different frame:
  - Ignored; the original frame data is written.
  - frame_ready stays 0 until after frame_done.
- Assert rst at idx=100:
  - All outputs return to reset values next cycle; frames_sent=0.
  - A new load restarts at sample 0.
- Samples 0x7FFF, 0x8000, 0x0080:
  - DISC_FEEDER_CLAMP_EN defined: written as 0x0100, 0xFF00, 0x0080.
  - Undefined: written unchanged.
- Preload frames_sent to 0xFFFF via 65535 fast frames (or force), then complete one more: frames_sent=0.

Source files
------------

// File: rtl/disc_sample_feeder.sv
// Streams one latched Q8.8 frame into the discriminator sample FIFO, then starts the pipeline and waits for done.
// Optional build macro DISC_FEEDER_CLAMP_EN saturates each written sample to [-256, +256].
module disc_sample_feeder #(
  parameter int unsigned SAMPLE_COUNT = 256,
  parameter int unsigned DATA_WIDTH   = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               load,
  input  logic [DATA_WIDTH*SAMPLE_COUNT-1:0] frame_flat,
  output logic                               frame_ready,
  output logic                               fifo_wr_en,
  output logic [DATA_WIDTH-1:0]              fifo_wr_data,
  input  logic                               fifo_full,
  output logic                               disc_start,
  input  logic                               disc_busy,
  input  logic                               disc_done,
  output logic                               busy,
  output logic                               frame_done,
  output logic [15:0]                        frames_sent
);

  localparam int unsigned IDX_W = (SAMPLE_COUNT > 1) ? $clog2(SAMPLE_COUNT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLE_COUNT - 1);

  typedef enum logic [1:0] {IDLE, WRITE, START, WAIT_DONE} state_t;

  state_t                              state, state_nxt;
  logic [DATA_WIDTH*SAMPLE_COUNT-1:0]  shadow;
  logic [IDX_W-1:0]                    idx;
  logic signed [DATA_WIDTH-1:0]        sample;
  logic                                accept_load;
  logic                                wr_fire;
  logic                                finish;

  assign accept_load = (state == IDLE) && load;
  assign wr_fire     = (state == WRITE) && !fifo_full;
  assign finish      = (state == WAIT_DONE) && disc_done;

  always_comb begin
    sample = shadow[idx*DATA_WIDTH +: DATA_WIDTH];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (load) state_nxt = WRITE;
      WRITE:     if (!fifo_full && idx == LAST_IDX) state_nxt = START;
      START:     if (disc_busy) state_nxt = WAIT_DONE;
      WAIT_DONE: if (disc_done) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    frame_ready = (state == IDLE);
    busy        = (state != IDLE);
    fifo_wr_en  = wr_fire;
`ifdef DISC_FEEDER_CLAMP_EN
    if (sample > $signed(DATA_WIDTH'(256)))
      fifo_wr_data = DATA_WIDTH'(256);
    else if (sample < $signed(DATA_WIDTH'(-256)))
      fifo_wr_data = DATA_WIDTH'(-256);
    else
      fifo_wr_data = sample;
`else
    fifo_wr_data = sample;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      idx    <= '0;
    end else if (accept_load) begin
      shadow <= frame_flat;
      idx    <= '0;
    end else if (wr_fire) begin
      idx <= idx + 1'b1;
    end
  end

  // disc_start rises on the final write so it is already high in the first START cycle
  always_ff @(posedge clk) begin
    if (rst)
      disc_start <= 1'b0;
    else if (wr_fire && idx == LAST_IDX)
      disc_start <= 1'b1;
    else if (state == START && disc_busy)
      disc_start <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done  <= 1'b0;
      frames_sent <= '0;
    end else begin
      frame_done <= finish;
      if (finish) frames_sent <= frames_sent + 16'd1;
    end
  end

endmodule

// File: tb/tb_disc_sample_feeder.sv
// Directed bench for disc_sample_feeder: frame streaming, backpressure, ignored loads, reset abort, clamp table, counter wrap.
// Expected clamp results follow DISC_FEEDER_CLAMP_EN when it is defined for the build.
module tb_disc_sample_feeder;
  localparam int SC = 256;
  localparam int DW = 16;
  localparam int FW = SC * DW;
`ifdef DISC_FEEDER_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic [FW-1:0] frame_flat = '0;
  logic          frame_ready;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_wr_data;
  logic          fifo_full = 1'b0;
  logic          disc_start;
  logic          disc_busy = 1'b0;
  logic          disc_done = 1'b0;
  logic          busy;
  logic          frame_done;
  logic [15:0]   frames_sent;

  disc_sample_feeder #(.SAMPLE_COUNT(SC), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .load(load), .frame_flat(frame_flat),
    .frame_ready(frame_ready), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_full(fifo_full), .disc_start(disc_start), .disc_busy(disc_busy),
    .disc_done(disc_done), .busy(busy), .frame_done(frame_done), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] smp;
    logic [DW-1:0] exp;
  } vec_t;

  int            checks = 0;
  int            errors = 0;
  logic [15:0]   exp_fs = '0;
  logic [DW-1:0] wr_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] ramp(input int base);
    logic [FW-1:0] f;
    for (int i = 0; i < SC; i++) f[i*DW +: DW] = DW'(i + base);
    return f;
  endfunction

  // One full frame: load, stream, start handshake (busy 2 cycles after start), done 10 cycles later.
  task automatic run_frame(input logic [FW-1:0] f, input logic [FW-1:0] exp_f,
                           input bit toggle_full, input bit poke_load, input logic [FW-1:0] f2);
    int c, ds_at, ds_fall, fd_at, fd_pulses, n_full, first_wr, last_wr, bad_busy, bad_data, first_bad;
    logic [15:0] fs_before, fs_at_done;
    bit idle_at_done;
    ds_at = -1; ds_fall = -1; fd_at = -1; fd_pulses = 0; n_full = 0;
    first_wr = -1; last_wr = -1; bad_busy = 0; bad_data = 0; first_bad = -1;
    fs_before = '0; fs_at_done = '0; idle_at_done = 1'b0;
    wr_q.delete();
    @(posedge clk); #1;
    load = 1'b1; frame_flat = f;
    for (c = 1; c < 2000; c++) begin
      @(posedge clk); #1;
      fifo_full = toggle_full && (ds_at < 0) && (c % 2 == 0);
      disc_busy = (ds_at >= 0) && (c >= ds_at + 2) && (c <= ds_at + 12);
      disc_done = (ds_at >= 0) && (c == ds_at + 12);
      load      = poke_load && ((c == 50) || (ds_at >= 0 && c == ds_at + 12));
      if (poke_load) frame_flat = f2;
      @(negedge clk);
      if (busy && wr_q.size() < SC && fifo_full) n_full++;
      if (fifo_wr_en) begin
        wr_q.push_back(fifo_wr_data);
        if (first_wr < 0) first_wr = c;
        last_wr = c;
      end
      if (disc_start && ds_at < 0) ds_at = c;
      if (!disc_start && ds_at >= 0 && ds_fall < 0) ds_fall = c;
      if (frame_done) begin
        fd_pulses++;
        if (fd_at < 0) begin
          fd_at = c; fs_at_done = frames_sent; idle_at_done = !busy;
        end
      end
      if (fd_at < 0 && (frame_ready || !busy)) bad_busy++;
      if (fd_at < 0) fs_before = frames_sent;
      if (ds_at >= 0 && c >= ds_at + 15) break;
    end
    load = 1'b0; fifo_full = 1'b0; disc_busy = 1'b0; disc_done = 1'b0;
    chk("frame_timeout", (fd_at >= 0), 1);
    for (int i = 0; i < SC && i < wr_q.size(); i++)
      if (wr_q[i] !== exp_f[i*DW +: DW]) begin
        bad_data++;
        if (first_bad < 0) first_bad = i;
      end
    if (bad_data != 0) $display("first bad sample index %0d", first_bad);
    chk("wr_count", wr_q.size(), SC);
    chk("wr_data_mismatches", bad_data, 0);
    chk("first_wr_cycle", first_wr, 1);
    chk("last_wr_cycle", last_wr, SC + n_full);
    chk("start_cycle", ds_at, SC + 1 + n_full);
    chk("start_fall_cycle", ds_fall, ds_at + 3);
    chk("busy_until_done", bad_busy, 0);
    chk("done_cycle", fd_at, ds_at + 13);
    chk("done_pulses", fd_pulses, 1);
    chk("fs_before_done", fs_before, exp_fs);
    exp_fs = exp_fs + 16'd1;
    chk("fs_at_done", fs_at_done, exp_fs);
    chk("idle_at_done", idle_at_done, 1);
    if (toggle_full) chk("full_cycles", n_full, SC - 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_frame_ready"}, frame_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_disc_start"}, disc_start, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_fifo_wr_en"}, fifo_wr_en, 0);
    chk({tag, "_frames_sent"}, frames_sent, 0);
  endtask

  initial begin
    vec_t          tbl[8];
    logic [FW-1:0] fin, fexp;

    tbl[0] = '{16'h7FFF, CLAMP ? 16'h0100 : 16'h7FFF};
    tbl[1] = '{16'h8000, CLAMP ? 16'hFF00 : 16'h8000};
    tbl[2] = '{16'h0080, 16'h0080};
    tbl[3] = '{16'h0100, 16'h0100};
    tbl[4] = '{16'h0101, CLAMP ? 16'h0100 : 16'h0101};
    tbl[5] = '{16'hFF00, 16'hFF00};
    tbl[6] = '{16'hFEFF, CLAMP ? 16'hFF00 : 16'hFEFF};
    tbl[7] = '{16'hFFFF, 16'hFFFF};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("rst");
    chk("rst_wr_data", fifo_wr_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("post_rst");

    run_frame(ramp(0), ramp(0), 1'b0, 1'b0, '0);
    run_frame(ramp(0), ramp(0), 1'b1, 1'b0, '0);
    run_frame(ramp(16'h1000), ramp(16'h1000), 1'b0, 1'b1, ramp(16'h2000));

    fin = ramp(0); fexp = ramp(0);
    for (int i = 0; i < 8; i++) begin
      fin[i*DW +: DW]  = tbl[i].smp;
      fexp[i*DW +: DW] = tbl[i].exp;
    end
    run_frame(fin, fexp, 1'b0, 1'b0, '0);
    for (int i = 0; i < 8; i++) chk($sformatf("clamp_vec%0d", i), wr_q[i], tbl[i].exp);

    // Abort mid-frame: 100 samples written, reset, then a fresh frame restarts at sample 0
    @(posedge clk); #1;
    load = 1'b1; frame_flat = ramp(16'h0300);
    @(posedge clk); #1;
    load = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_idx100_data", fifo_wr_data, 16'h0300 + 16'd100);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("abort");
    exp_fs = '0;
    run_frame(ramp(0), ramp(0), 1'b0, 1'b0, '0);

    @(posedge clk); #1;
    force dut.frames_sent = 16'hFFFF;
    @(negedge clk);
    release dut.frames_sent;
    @(posedge clk); #1;
    chk("preload_fs", frames_sent, 16'hFFFF);
    exp_fs = 16'hFFFF;
    run_frame(ramp(5), ramp(5), 1'b0, 1'b0, '0);
    chk("wrap_fs", frames_sent, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
